// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP arbiter.
// The state enum, DRP widths, XADC register addresses and the helpers that
// pull one requester's field out of a packed two-port bus.
package xadc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  // XADC register addresses
  localparam logic [ADDR_W-1:0] AUX0 = 7'h10;
  localparam logic [ADDR_W-1:0] AUX1 = 7'h11;
  localparam logic [ADDR_W-1:0] AUX2 = 7'h12;
  localparam logic [ADDR_W-1:0] AUX3 = 7'h13;
  localparam logic [ADDR_W-1:0] CFG0 = 7'h40;
  localparam logic [ADDR_W-1:0] CFG1 = 7'h41;
  localparam logic [ADDR_W-1:0] CFG2 = 7'h42;

  // Select the address of requester idx from {addr1, addr0}
  function automatic logic [ADDR_W-1:0] sel_addr(input logic [2*ADDR_W-1:0] a,
                                                 input logic idx);
    return idx ? a[2*ADDR_W-1:ADDR_W] : a[ADDR_W-1:0];
  endfunction

  // Select the write data of requester idx from {wdata1, wdata0}
  function automatic logic [DATA_W-1:0] sel_data(input logic [2*DATA_W-1:0] d,
                                                 input logic idx);
    return idx ? d[2*DATA_W-1:DATA_W] : d[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/xadc_drp_arbiter_rr.sv
// Two-port round-robin grant: when both ports want the bus the pointer picks
// the winner, otherwise the single requester wins. Grant is one-hot or zero.
module xadc_rr_arb (
  input  logic [1:0] pending_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // Pointer only matters on a tie
  always_comb begin
    grant_o = pending_i;
    if (pending_i == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// XADC DRP arbiter: shares one DRP master port between a config writer
// (port 0) and a channel poller (port 1), one transaction at a time.
// Optional feature: define XADC_DRP_TIMEOUT_EN to bound the DRDY wait to
// TIMEOUT_CYCLES and report an expired wait on err.
//
// Handshake: req[i] is a one-cycle strobe that parks a request in pending[i];
// we/addr/wdata for that port stay stable until ack[i], a one-cycle pulse
// that also qualifies rdata (and err). A strobe on an already pending port
// is dropped.
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          err,
  output logic [ADDR_W-1:0]   DADDR,
  output logic                DEN,
  output logic [DATA_W-1:0]   DI,
  output logic                DWE,
  input  logic [DATA_W-1:0]   DO,
  input  logic                DRDY,
  input  logic                BUSY,
  output state_t              state_o
);

  state_t              state_q, state_d;
  logic [1:0]          pending_q, pending_d;
  logic                rr_q;
  logic [1:0]          grant_q;
  logic                wr_q;
  logic                den_q, dwe_q;
  logic [ADDR_W-1:0]   daddr_q;
  logic [DATA_W-1:0]   di_q, rdata_q;

  logic [1:0]          req_eff, grant;
  logic                gidx, start, drdy_hit, tmo_hit;

  // A fresh strobe competes in the same cycle it arrives
  assign req_eff  = pending_q | req;
  assign gidx     = grant[1];
  assign start    = (state_q == ST_IDLE) && !BUSY && (req_eff != 2'b00);
  assign drdy_hit = (state_q == ST_WAIT) && DRDY;

  xadc_rr_arb u_arb (
    .pending_i (req_eff),
    .ptr_i     (rr_q),
    .grant_o   (grant)
  );

`ifdef XADC_DRP_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
  logic       tmo_q;

  assign tmo_hit = (state_q == ST_WAIT) && !DRDY && (cnt_q == TMO_LAST);

  // Wait-cycle counter, zero whenever not in WAIT; tmo_q marks a timed-out RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_WAIT) ? cnt_q + 8'd1 : 8'd0;
      if (drdy_hit || tmo_hit) tmo_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Dropped strobes leave pending untouched; ack clears the served port
  assign pending_d = (pending_q & ~ack) | (req & ~pending_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_WAIT;
      ST_WAIT: if (drdy_hit || tmo_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: grant latch, DRP strobe/address/data, read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 2'b00;
      rr_q      <= 1'b0;
      grant_q   <= 2'b00;
      wr_q      <= 1'b0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      den_q     <= start;
      dwe_q     <= start & we[gidx];
      if (start) begin
        grant_q <= grant;
        rr_q    <= ~gidx;
        wr_q    <= we[gidx];
        daddr_q <= sel_addr(addr, gidx);
        di_q    <= sel_data(wdata, gidx);
      end
      if (drdy_hit)     rdata_q <= wr_q ? '0 : DO;
      else if (tmo_hit) rdata_q <= '0;
    end
  end

  // Outputs: ack/err pulse in RESP only, DRP drive straight from registers
  always_comb begin
    ack     = (state_q == ST_RESP) ? grant_q : 2'b00;
`ifdef XADC_DRP_TIMEOUT_EN
    err     = (state_q == ST_RESP && tmo_q) ? grant_q : 2'b00;
`else
    err     = 2'b00;
`endif
    rdata   = rdata_q;
    DEN     = den_q;
    DWE     = dwe_q;
    DADDR   = daddr_q;
    DI      = di_q;
    state_o = state_q;
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter: a vector table of single-port
// transactions plus hand-written sequences for tie-break, fairness, BUSY
// stall, reset during WAIT and (when XADC_DRP_TIMEOUT_EN is defined) timeout.
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [13:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic [1:0]  err;
  logic [6:0]  DADDR;
  logic        DEN;
  logic [15:0] DI;
  logic        DWE;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b0;
  logic        BUSY = 1'b0;
  state_t      state_o;

  int checks = 0;
  int errors = 0;

  xadc_drp_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .DADDR(DADDR), .DEN(DEN), .DI(DI),
    .DWE(DWE), .DO(DO), .DRDY(DRDY), .BUSY(BUSY), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic rst_dut();
    rst = 1'b1; req = '0; DRDY = 1'b0; BUSY = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Wait (bounded) for DEN, check the DRP command, hold DRDY off for k cycles,
  // then check the ack cycle. Returns at the negedge of the ack cycle.
  task automatic serve(input int port, input logic [6:0] daddr, input logic dwe,
                       input logic [15:0] di, input int k, input logic [15:0] do_val,
                       input logic [15:0] exp_rdata, output int waited);
    logic [1:0] exp_ack;
    exp_ack = (port == 1) ? 2'b10 : 2'b01;
    waited = 0;
    while (!DEN && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!DEN) begin
      checks++;
      errors++;
      $display("FAIL den_wait actual=no DEN required=DEN within 40 cycles");
      return;
    end
    chk("daddr", DADDR, daddr);
    chk("dwe", DWE, dwe);
    chk("di", DI, di);
    for (int j = 0; j <= k; j++) begin
      if (j > 0) chk("den_single", DEN, 1'b0);
      chk("ack_early", ack, 2'b00);
      if (j == k) begin
        DRDY = 1'b1;
        DO   = do_val;
      end
      @(negedge clk);
    end
    DRDY = 1'b0;
    DO   = 16'hDEAD;
    chk("ack", ack, exp_ack);
    chk("rdata", rdata, exp_rdata);
    chk("err", err, 2'b00);
    chk("den_resp", DEN, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [13:0] addr;
    logic [31:0] wdata;
    int          k;
    logic [15:0] do_val;
    int          port;
    logic [6:0]  daddr;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w;
    vecs[0] = '{2'b01, 2'b01, {7'h00, CFG0}, {16'h0000, 16'hBEEF}, 0, 16'h1111, 0, CFG0, 1'b1, 16'hBEEF, 16'h0000};
    vecs[1] = '{2'b10, 2'b00, {AUX1, 7'h00}, 32'h0,                 3, 16'hA5F0, 1, AUX1, 1'b0, 16'h0000, 16'hA5F0};
    vecs[2] = '{2'b01, 2'b00, {7'h00, AUX3}, {16'h0000, 16'h5555}, 1, 16'h7E57, 0, AUX3, 1'b0, 16'h5555, 16'h7E57};
    vecs[3] = '{2'b10, 2'b10, {CFG2, 7'h00}, {16'hCAFE, 16'h0000}, 2, 16'hFFFF, 1, CFG2, 1'b1, 16'hCAFE, 16'h0000};
    vecs[4] = '{2'b01, 2'b00, {7'h00, AUX0}, 32'h0,                 5, 16'h0001, 0, AUX0, 1'b0, 16'h0000, 16'h0001};

    // Reset state
    rst_dut();
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_den", DEN, 1'b0);
    chk("rst_dwe", DWE, 1'b0);
    chk("rst_daddr", DADDR, 7'h00);
    chk("rst_di", DI, 16'h0000);
    chk("rst_ack", ack, 2'b00);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_err", err, 2'b00);

    // Table: single-port transactions, DEN must follow the strobe directly
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata; req = vecs[i].req;
      @(negedge clk);
      req = '0;
      serve(vecs[i].port, vecs[i].daddr, vecs[i].dwe, vecs[i].di, vecs[i].k,
            vecs[i].do_val, vecs[i].rdata, w);
      chk("vec_latency", w, 0);
    end

    // Simultaneous: port 0 write wins after reset, port 1 read follows 3 cycles later
    rst_dut();
    we = 2'b01; addr = {AUX0, CFG1}; wdata = {16'h0000, 16'h1234}; req = 2'b11;
    @(negedge clk);
    req = '0;
    serve(0, CFG1, 1'b1, 16'h1234, 0, 16'h9999, 16'h0000, w);
    chk("sim_lat0", w, 0);
    serve(1, AUX0, 1'b0, 16'h0000, 1, 16'h0BAD, 16'h0BAD, w);
    chk("sim_spacing", w, 2);

    // Fairness: both ports re-request right after every ack
    rst_dut();
    we = 2'b00; addr = {AUX3, AUX2}; wdata = {16'h0002, 16'h0001}; req = 2'b11;
    @(negedge clk);
    req = '0;
    for (int t = 0; t < 8; t++) begin
      if (t > 0) begin
        @(negedge clk);
        req = 2'b11;
        @(negedge clk);
        req = '0;
      end
      if (t % 2 == 0) serve(0, AUX2, 1'b0, 16'h0001, t % 3, 16'h0100 + 16'(t), 16'h0100 + 16'(t), w);
      else            serve(1, AUX3, 1'b0, 16'h0002, t % 3, 16'h0100 + 16'(t), 16'h0100 + 16'(t), w);
      chk("fair_lat", w, 0);
    end

    // BUSY stall: no DEN while BUSY, DEN the cycle after it falls
    rst_dut();
    BUSY = 1'b1; we = 2'b00; addr = {7'h00, AUX1}; wdata = '0; req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = '0;
      chk("busy_den", DEN, 1'b0);
    end
    BUSY = 1'b0;
    @(negedge clk);
    serve(0, AUX1, 1'b0, 16'h0000, 2, 16'h4321, 16'h4321, w);
    chk("busy_lat", w, 0);

    // Reset during WAIT: transaction and the other pending request vanish
    rst_dut();
    we = 2'b00; addr = {AUX1, AUX0}; req = 2'b11;
    @(negedge clk);
    req = '0;
    chk("rw_den", DEN, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_state", state_o, ST_IDLE);
    chk("rw_den_off", DEN, 1'b0);
    chk("rw_ack", ack, 2'b00);
    DRDY = 1'b1; DO = 16'hFFFF;
    @(negedge clk);
    DRDY = 1'b0;
    chk("rw_late_drdy_ack", ack, 2'b00);
    chk("rw_late_drdy_state", state_o, ST_IDLE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rw_quiet_den", DEN, 1'b0);
      chk("rw_quiet_ack", ack, 2'b00);
    end

`ifdef XADC_DRP_TIMEOUT_EN
    // Timeout: DRDY withheld, RESP after 10 WAIT cycles with err
    we = 2'b00; addr = {7'h00, AUX0}; req = 2'b01;
    @(negedge clk);
    req = '0;
    chk("to_den", DEN, 1'b1);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk("to_ack_early", ack, 2'b00);
    end
    @(negedge clk);
    chk("to_ack", ack, 2'b01);
    chk("to_err", err, 2'b01);
    chk("to_rdata", rdata, 16'h0000);
    @(negedge clk);
    chk("to_idle", state_o, ST_IDLE);
    chk("to_ack_off", ack, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadc_drp_arbiter.md
XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the DRDY wait limit in clk cycles (range 2..255, 8-bit counter).
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester one-cycle request strobe; bit 0 = config writer, bit 1 = channel poller.
REQ-005 we  in  2  per-requester write enable; 1 = DRP write, 0 = DRP read; held stable from req until ack.
REQ-006 addr  in  14  packed DRP addresses, {addr1[6:0], addr0[6:0]}; held stable from req until ack.
REQ-007 wdata  in  32  packed write data, {wdata1, wdata0}; held stable from req until ack.
REQ-008 ack  out  2  one-cycle completion pulse to the served requester.
REQ-009 rdata  out  16  DRP read data; valid only in the ack cycle.
REQ-010 err  out  2  one-cycle timeout flag, coincident with ack.
REQ-011 DADDR  out  7, DEN  out  1, DI  out  16, DWE  out  1: DRP master outputs to the XADC.
REQ-012 DO  in  16, DRDY  in  1, BUSY  in  1: DRP/status inputs from the XADC.

Function
REQ-013 A req[i] pulse sets pending[i]; pending[i] clears when ack[i] is issued.
REQ-014 A req[i] pulse while pending[i] is already set is dropped and has no effect.
REQ-015 States: IDLE, WAIT, RESP.
REQ-016 IDLE -> WAIT when BUSY=0 and (pending | req) != 0. The grant is latched, and DADDR/DI/DWE are loaded from the granted port.
REQ-017 DEN is asserted for exactly the first cycle of WAIT. DWE equals we[g] during that cycle and is 0 at all other times.
REQ-018 With BUSY=1, the block stays in IDLE and issues no DEN.
REQ-019 Arbitration is round-robin. When both ports are pending, the port not served last wins. The pointer favours port 0 after reset.
REQ-020 WAIT -> RESP on DRDY=1. DO is captured into rdata in that edge.
REQ-021 RESP lasts one cycle: ack[g]=1, rdata valid. Then RESP -> IDLE.
REQ-022 Latency: req at edge T with the block idle and BUSY low gives DEN=1 in cycle T+1. DRDY in cycle T+1+k gives ack in cycle T+2+k.
REQ-023 For writes, rdata is 16'h0000 in the ack cycle.
REQ-024 DRDY in IDLE or RESP is ignored.
REQ-025 DADDR/DI hold their last values outside WAIT. DEN=0 outside the first WAIT cycle.
REQ-026 Minimum spacing between consecutive DEN pulses is 3 cycles.

Reset
REQ-027 Reset values: state=IDLE, pending=0, rr pointer=port 0, DEN=0, DWE=0, DADDR=0, DI=0, ack=0, rdata=0, err=0, timeout counter=0.
REQ-028 Reset mid-transaction abandons the transaction: no ack or err for it, and pending requests are discarded.

Configuration
REQ-029 When XADC_DRP_TIMEOUT_EN is defined, an 8-bit counter runs in WAIT. If it reaches TIMEOUT_CYCLES without DRDY, the block enters RESP with rdata=16'h0000, ack[g]=1 and err[g]=1.
REQ-030 When XADC_DRP_TIMEOUT_EN is undefined, WAIT persists until DRDY, err is tied to 0, and no counter is synthesised.

Structure
REQ-031 Package xadc_pkg holds:
- the state enum;
- DRP width constants (ADDR_W=7, DATA_W=16);
- XADC register addresses: AUX0..AUX3 = 7'h10..7'h13, CFG0..CFG2 = 7'h40..7'h42.
REQ-032 The round-robin grant logic is a sub-module, xadc_rr_arb (inputs: pending and pointer; output: one-hot grant).

Verification
REQ-033 Single read: req=2'b10, addr1=7'h11, DRDY 3 cycles after DEN with DO=16'hA5F0. Required: one DEN with DWE=0 and DADDR=7'h11; ack=2'b10 and rdata=16'hA5F0 one cycle after DRDY.
REQ-034 Simultaneous: req=2'b11, write 16'h1234 to 7'h41 on port 0 and read 7'h10 on port 1. Required: port 0 is served first (DWE=1, DI=16'h1234), then port 1; the acks arrive in that order.
REQ-035 Fairness: both ports re-request immediately after every ack for 8 transactions. Required: grants strictly alternate 0,1,0,1,...
REQ-036 BUSY=1 for 20 cycles with req=2'b01. Required: no DEN while BUSY=1; DEN appears in the cycle after BUSY falls.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=10), DRDY withheld. Required: ack[0]=1 and err[0]=1 after 10 WAIT cycles, rdata=0, then return to IDLE.
REQ-038 rst asserted in WAIT. Required: next cycle IDLE, DEN=0, no ack; a later DRDY is ignored.
